// File: rtl/pipeline_control_if.sv
// Handshake bundle between the pipeline datapath and its hazard/stall controller.
// Master drives the stage fields and memory status; slave returns enables and flushes.
interface pipeline_control_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rt;
    logic       ex_memread;
    logic       mem_branch_taken;
    logic       mem_jump;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_write;
    logic       exmem_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;
    logic       pc_src;
    logic       mem_error;

    modport master (
        output id_rs, id_rt, ex_rt, ex_memread,
        output mem_branch_taken, mem_jump, mem_req, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  pc_src, mem_error
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_memread,
        input  mem_branch_taken, mem_jump, mem_req, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output pc_src, mem_error
    );
endinterface

// File: rtl/pipeline_control.sv
// Hazard, redirect and memory-stall controller for a 5-stage pipeline.
// Optional PIPELINE_STALL_COUNT_EN adds saturating stall/redirect counters.
module pipeline_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_control_if.slave   bus
`ifdef PIPELINE_STALL_COUNT_EN
    ,
    output logic [15:0]         stall_cycles,
    output logic [15:0]         redirect_count
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_error_q, mem_error_d;

    logic load_use;
    logic redirect;
    logic mem_busy;
    logic redirect_act;

    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic pc_src;

    // Hazard terms decoded from the stage fields.
    always_comb begin
        load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                   ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
        redirect = bus.mem_branch_taken | bus.mem_jump;
        mem_busy = bus.mem_req & ~bus.mem_ready;
    end

    // Next state and zero-cycle control outputs; reset forces everything idle.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_error_d  = mem_error_q;
        redirect_act = 1'b0;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        pc_src       = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    memwb_flush = 1'b1;
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = CW'(1);
                    end else if (wait_cnt_q == CW'(MEM_TIMEOUT)) begin
                        state_d     = HALT;
                        mem_error_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end else begin
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    idex_write  = 1'b1;
                    exmem_write = 1'b1;
                    if (redirect) begin
                        redirect_act = 1'b1;
                        pc_src       = 1'b1;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        exmem_flush  = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (rst) begin
            redirect_act = 1'b0;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            exmem_flush  = 1'b0;
            memwb_flush  = 1'b0;
            pc_src       = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.idex_write  = idex_write;
    assign bus.exmem_write = exmem_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_flush = memwb_flush;
    assign bus.pc_src      = pc_src;
    assign bus.mem_error   = mem_error_q;

`ifdef PIPELINE_STALL_COUNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] redirect_count_q, redirect_count_d;

    // Saturating counters: PC-hold cycles outside HALT, and acted redirects.
    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;
        if (!pc_write && (state_q != HALT) && (stall_cycles_q != 16'hFFFF))
            stall_cycles_d = stall_cycles_q + 16'd1;
        if (redirect_act && (redirect_count_q != 16'hFFFF))
            redirect_count_d = redirect_count_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized + directed bench for pipeline_control against a rule-level model.
// Define PIPELINE_STALL_COUNT_EN to also check the stall/redirect counters.
module tb_pipeline_control;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_control_if bus ();

`ifdef PIPELINE_STALL_COUNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] redirect_count;
`endif

    pipeline_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef PIPELINE_STALL_COUNT_EN
        ,
        .stall_cycles(stall_cycles),
        .redirect_count(redirect_count)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: halted flag, length of the current run of busy cycles, counters.
    bit halted   = 1'b0;
    int busy_run = 0;
    int m_stall  = 0;
    int m_redir  = 0;
    logic [9:0] m_e;

    localparam logic [9:0] O_NORM = 10'b1111_0000_00;
    localparam logic [9:0] O_LU   = 10'b0011_0100_00;
    localparam logic [9:0] O_RED  = 10'b1111_1110_10;
    localparam logic [9:0] O_BUSY = 10'b0000_0001_00;
    localparam logic [9:0] O_HALT = 10'b0000_0000_01;
    localparam logic [9:0] O_ZERO = 10'b0000_0000_00;

    function automatic logic [9:0] dut_out();
        return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush,
                bus.pc_src, bus.mem_error};
    endfunction

    function automatic logic [9:0] expect_out();
        logic lu, rd, bz;
        bz = bus.mem_req & ~bus.mem_ready;
        rd = bus.mem_branch_taken | bus.mem_jump;
        lu = bus.ex_memread && bus.ex_rt != 0 &&
             (bus.ex_rt == bus.id_rs || bus.ex_rt == bus.id_rt);
        if (rst)    return O_ZERO;
        if (halted) return O_HALT;
        if (bz)     return O_BUSY;
        if (rd)     return O_RED;
        if (lu)     return O_LU;
        return O_NORM;
    endfunction

    // Model update on each edge using the inputs that were present at it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            halted   = 1'b0;
            busy_run = 0;
            m_stall  = 0;
            m_redir  = 0;
        end else if (!halted) begin
            m_e = expect_out();
            if (!m_e[9] && m_stall < 65535) m_stall++;
            if (m_e == O_RED && m_redir < 65535) m_redir++;
            if (m_e == O_BUSY) begin
                busy_run++;
                if (busy_run == TO + 1) halted = 1'b1;
            end else begin
                busy_run = 0;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        vectors++;
        if (dut_out() !== expect_out()) begin
            miscompares++;
            $display("FAIL outputs t=%0t got=%b want=%b", $time, dut_out(), expect_out());
        end
`ifdef PIPELINE_STALL_COUNT_EN
        vectors++;
        if (stall_cycles !== 16'(m_stall) || redirect_count !== 16'(m_redir)) begin
            miscompares++;
            $display("FAIL counters t=%0t got=%0d/%0d want=%0d/%0d", $time,
                     stall_cycles, redirect_count, m_stall, m_redir);
        end
`endif
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                         input logic mr, input logic br, input logic jp,
                         input logic rq, input logic rdy);
        bus.id_rs            = rs;
        bus.id_rt            = rt;
        bus.ex_rt            = ert;
        bus.ex_memread       = mr;
        bus.mem_branch_taken = br;
        bus.mem_jump         = jp;
        bus.mem_req          = rq;
        bus.mem_ready        = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int hold;
        int pct_req;
        int pct_rdy;
        idle();
        #2;
        chk("reset_out", 16'(dut_out()), 16'(O_ZERO));
        tick();
        tick();
        rst = 1'b0;

        drive(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("load_use", 16'(dut_out()), 16'(O_LU));
        tick();
        drive(5'd5, 5'd9, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("load_use_clear", 16'(dut_out()), 16'(O_NORM));
        drive(5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("rt_zero_no_stall", 16'(dut_out()), 16'(O_NORM));
        tick();
        drive(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("jump_over_lu", 16'(dut_out()), 16'(O_RED));
        tick();
        idle();
        #1 chk("after_jump", 16'(dut_out()), 16'(O_NORM));
        tick();
        drive(5'd7, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("load_use_rt", 16'(dut_out()), 16'(O_LU));
        tick();
        idle();
`ifdef PIPELINE_STALL_COUNT_EN
        #1 chk("stall_cycles_2", stall_cycles, 16'd2);
        chk("redirect_count_1", redirect_count, 16'd1);
`endif

        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("mem_busy", 16'(dut_out()), 16'(O_BUSY));
            tick();
        end
        bus.mem_ready = 1'b1;
        #1 chk("mem_ready_adv", 16'(dut_out()), 16'(O_NORM));
        tick();
        idle();

        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 chk("busy_hides_redirect", 16'(dut_out()), 16'(O_BUSY));
        tick();
        bus.mem_ready = 1'b1;
        #1 chk("redirect_on_ready", 16'(dut_out()), 16'(O_RED));
        tick();
        idle();

        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.mem_error && n < 20);
        chk("halt_latency", 16'(n), 16'(TO + 1));
        #1 chk("halt_out", 16'(dut_out()), 16'(O_HALT));
        drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        chk("halt_sticky", 16'(dut_out()), 16'(O_HALT));
        rst = 1'b1;
        #1 chk("rst_leaves_halt", 16'(dut_out()), 16'(O_ZERO));
        tick();
        rst = 1'b0;
        idle();
        #1 chk("run_after_rst", 16'(dut_out()), 16'(O_NORM));

        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        #1 rst = 1'b1;
        #1 chk("rst_mid_wait", 16'(dut_out()), 16'(O_ZERO));
        tick();
        rst = 1'b0;
        idle();
        #1 chk("run_after_wait_rst", 16'(dut_out()), 16'(O_NORM));

        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            hold = halted ? hold + 1 : 0;
            if (rst) rst = 1'b0;
            else if (hold >= 3 || $urandom_range(99) == 0) rst = 1'b1;
            pct_req = ((i / 250) % 2 == 1) ? 90 : 30;
            pct_rdy = ((i / 250) % 2 == 1) ? 20 : 70;
            drive(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  1'($urandom_range(1)),
                  $urandom_range(99) < 10,
                  $urandom_range(99) < 10,
                  $urandom_range(99) < pct_req,
                  $urandom_range(99) < pct_rdy);
        end
        tick();
        rst = 1'b0;

`ifdef PIPELINE_STALL_COUNT_EN
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65540) tick();
        chk("stall_saturate", stall_cycles, 16'hFFFF);
        idle();
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max consecutive MEM_WAIT cycles before the block halts.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
REQ-005 ex_rt  in  5  destination field of the instruction in EX (ID/EX outputs).
REQ-006 ex_memread  in  1  instruction in EX is a load.
REQ-007 mem_branch_taken, mem_jump  in  1 each  taken branch / jump in MEM (EX/MEM outputs).
REQ-008 mem_req  in  1  MEM-stage instruction accesses data memory (Memread_Exe | Memwrite_Exe).
REQ-009 mem_ready  in  1  data memory completes the access this cycle.
REQ-010 pc_write, ifid_write, idex_write, exmem_write  out  1 each  hold (0) / load (1) enables.
REQ-011 ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  insert bubble at next edge.
REQ-012 pc_src  out  1  select redirect target for PC.
REQ-013 mem_error  out  1  sticky, set on memory timeout.

Function
REQ-014 Terms: load_use = ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt); redirect = mem_branch_taken | mem_jump; mem_busy = mem_req & ~mem_ready.
REQ-015 States RUN, MEM_WAIT, HALT; outputs combinational from state and inputs (zero-cycle response).
REQ-016 RUN priority: mem_busy > redirect > load_use > normal.
REQ-017 RUN normal: all *_write=1, all flushes=0, pc_src=0; stay RUN.
REQ-018 RUN load_use: pc_write=0, ifid_write=0, idex_flush=1, others normal; stay RUN (one bubble; next cycle load is in MEM and load_use clears).
REQ-019 RUN redirect: pc_src=1, pc_write=1, ifid_flush=idex_flush=exmem_flush=1; stay RUN; load_use in the same cycle is ignored.
REQ-020 RUN mem_busy: all *_write=0, memwb_flush=1, other flushes 0; next state MEM_WAIT, wait_cnt<=1.
REQ-021 MEM_WAIT with mem_busy: outputs as REQ-020; wait_cnt increments; if wait_cnt==MEM_TIMEOUT next state HALT and mem_error<=1.
REQ-022 MEM_WAIT with mem_ready: outputs evaluated exactly as in RUN (REQ-016..019); next state RUN; wait_cnt<=0.
REQ-023 redirect concurrent with mem_busy is acted on only in the cycle mem_ready rises.
REQ-024 HALT: all *_write=0, all flushes=0, pc_src=0, mem_error=1; exits only via rst.
REQ-025 wait_cnt width = clog2(MEM_TIMEOUT+1); never wraps.

Reset
REQ-026 rst asserted: state=RUN, wait_cnt=0, mem_error=0, counters 0, immediately and independent of clk.
REQ-027 While rst asserted: all *_write=0, all flushes=0, pc_src=0.
REQ-028 First edge after rst deasserts behaves as RUN; reset during MEM_WAIT or HALT abandons the stall.

Configuration
REQ-029 Macro PIPELINE_STALL_COUNT_EN defined: outputs stall_cycles[15:0] (+1 each clk with pc_write=0 outside reset and HALT) and redirect_count[15:0] (+1 per REQ-019 cycle), both saturating at 16'hFFFF, cleared by rst.
REQ-030 Macro undefined: both ports and counters absent; all other behaviour identical.

Verification
REQ-031 ex_memread=1, ex_rt=5, id_rs=5 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; ex_rt=0 same case -> no stall.
REQ-032 mem_jump=1 in RUN -> pc_src=1, ifid/idex/exmem_flush=1 for one cycle; simultaneous load_use ignored.
REQ-033 mem_req=1, mem_ready low 3 cycles then high -> 3 cycles all writes 0 with memwb_flush=1, 4th cycle normal advance, back to RUN.
REQ-034 MEM_TIMEOUT=4, mem_ready held low -> HALT after 4 wait cycles, mem_error=1, stays until rst.
REQ-035 rst asserted mid-MEM_WAIT between edges -> state RUN, outputs per REQ-027 without a clock edge.
REQ-036 PIPELINE_STALL_COUNT_EN defined: 2 load-use stalls + 1 redirect -> stall_cycles=2, redirect_count=1; preload near 16'hFFFF -> saturates.
